sram_serial_ctrl: RTL and testbench
===================================

Name: sram_serial_ctrl

Overview:
- Parametrised front-end plus behavioural storage array for the mixed-signal SRAM macro.
- Write path:
  - Serial data enters a multi-lane shift register.
  - A completed word is loaded into a holding register.
  - The holding register is committed to the addressed row.
- Read path: registered, configurable-latency read that pulses data_valid.
- Successor to the single-lane serial-write SRAM top. Adds:
  - width/depth/lane/latency generalisation
  - fill-state tracking and a loaded-word holding buffer
  - protocol error flags

Parameters:
- ROWS, 16, number of words; addr width is clog2(ROWS).
- COLS, 8, word width in bits.
- LANES, 1, serial bits shifted per shift cycle. COLS must be divisible by LANES (elaboration check).
- RD_LAT, 1, cycles from r_en sample to data_valid, range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- addr  in  clog2(ROWS)  row address, shared by read and write.
- serial_in  in  LANES  serial data; lane LANES-1 is the oldest (MSB-side) bit.
- shift  in  1  shift serial_in into the shift register.
- load  in  1  move the completed word into the holding register.
- w_en  in  1  commit the holding register to mem[addr].
- r_en  in  1  read mem[addr].
- word_full  out  1  shift register holds COLS valid bits.
- hold_valid  out  1  holding register holds an uncommitted word.
- data_valid  out  1  one-cycle pulse; data_out is valid.
- data_out  out  COLS  read data; holds its last value between reads.
- proto_err  out  3  one-cycle pulse flags: bit0 shift overflow, bit1 load rejected, bit2 write without data.
- rd_par_err  out  1  parity mismatch on read; see Optional Feature.

Behaviour:
- Reset (asynchronous, arst_n low):
  - All outputs 0.
  - Shift register, bit counter, holding register, read pipeline and every mem row cleared to 0.
  - Fill FSM returns to FILL.
  - Reset during a shift sequence discards the partial word and any held word.
- Fill FSM, 2 states:
  - FILL: bit count cnt < COLS/LANES. On shift: shift_reg <= {shift_reg[COLS-LANES-1:0], serial_in}; cnt++. Go to FULL when cnt reaches COLS/LANES.
  - FULL: word_full=1.
    - shift: ignored, proto_err[0] pulse.
    - load with hold_valid=0: hold <= shift_reg, hold_valid <= 1, cnt <= 0, shift_reg <= 0, go to FILL.
    - load with hold_valid=1: rejected, proto_err[1] pulse, state unchanged.
- load in FILL (partial word): rejected, proto_err[1] pulse.
- shift and load in the same cycle: shift has priority. load is ignored with proto_err[1], whatever the state.
- Write:
  - w_en with hold_valid=1: mem[addr] <= hold; hold_valid <= 0 next cycle.
  - w_en with hold_valid=0: no write, proto_err[2] pulse.
- Load and write in the same cycle with hold_valid=1:
  - The write commits the old hold.
  - The load is accepted in the same edge; hold takes the new word and hold_valid stays 1.
  - Neither flag pulses.
- Read:
  - r_en samples addr and mem[addr] at edge N.
  - data_out/data_valid update at edge N+RD_LAT-1, i.e. visible RD_LAT cycles after r_en is asserted.
  - Back-to-back reads are allowed, one per cycle, fully pipelined.
- r_en and w_en in the same cycle, same addr: read returns the pre-write (old) data.
- Different addresses: both operations are independent.
- Address out of range (ROWS not a power of two):
  - Write is dropped.
  - Read returns 0 with data_valid still pulsing.
- Counter width: clog2(COLS/LANES)+1 bits. No wrap; saturation is enforced by the FULL state.

Optional Feature:
- Macro SRAM_PARITY_EN.
- Defined:
  - Each row stores an extra even-parity bit computed from hold at commit time.
  - On read, parity is recomputed and compared.
  - rd_par_err pulses aligned with data_valid on mismatch.
  - Bench fault-injection hook: a hierarchical force on the stored parity bit.
- Undefined: no parity storage; rd_par_err tied 0.

Decomposition:
- Package sram_pkg:
  - fill_state_e (FILL, FULL)
  - proto_err bit index localparams (ERR_SHIFT_OVF=0, ERR_LOAD_REJ=1, ERR_WR_EMPTY=2)
  - parity function
- One sub-module sram_serial_loader, owning:
  - shift register, counter and fill FSM
  - holding register and hold_valid
  - proto_err[1:0]
- The top keeps mem, the write commit, the read pipeline and parity.

Test Plan:
- Defaults (COLS=8, LANES=1, RD_LAT=1): shift bits 1,0,1,1,0,0,1,0; load; w_en addr=3; r_en addr=3 -> data_out=0xB2 with data_valid one cycle after r_en.
- LANES=2: shift pairs 2'b10,2'b11,2'b00,2'b01 -> word_full after the 4th shift; load/write/read of addr 5 returns 0xB1.
- Ninth shift in FULL -> proto_err[0] pulse, word unchanged. Load after only 5 shifts -> proto_err[1], hold_valid stays 0.
- Same cycle w_en+r_en at addr 2 (old 0x11, hold 0x22) -> read returns 0x11; next read returns 0x22.
- RD_LAT=3: r_en on addrs 0,1,2 in consecutive cycles -> data_valid high for 3 consecutive cycles starting 3 cycles after the first r_en, data in order.
- arst_n low mid-shift after 4 bits -> word_full=0, hold_valid=0, all rows read 0. With SRAM_PARITY_EN: force parity bit of row 3 -> rd_par_err pulses with data_valid.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types, error-flag bit positions and the parity helper for the serial-write SRAM.
// Parity storage is only built when SRAM_PARITY_EN is defined.
package sram_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_e;

  localparam int ERR_SHIFT_OVF = 0;
  localparam int ERR_LOAD_REJ  = 1;
  localparam int ERR_WR_EMPTY  = 2;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int PAR_MAX_W = 64;

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/sram_serial_ctrl_if.sv
// Command/status bundle of the serial-write SRAM front-end.
// fill_state is a debug view of the loader FSM.
interface sram_serial_ctrl_if #(
  parameter int ROWS  = 16,
  parameter int COLS  = 8,
  parameter int LANES = 1
);
  localparam int AW = (ROWS > 1) ? $clog2(ROWS) : 1;

  // shift/load/w_en/r_en are single-cycle strobes sampled on the rising edge.
  // There is no back-pressure; a refused strobe is reported on proto_err.
  logic [AW-1:0]           addr;
  logic [LANES-1:0]        serial_in;
  logic                    shift;
  logic                    load;
  logic                    w_en;
  logic                    r_en;
  logic                    word_full;
  logic                    hold_valid;
  logic                    data_valid;
  logic [COLS-1:0]         data_out;
  logic [2:0]              proto_err;
  logic                    rd_par_err;
  sram_pkg::fill_state_e   fill_state;

  modport master (
    output addr, serial_in, shift, load, w_en, r_en,
    input  word_full, hold_valid, data_valid, data_out, proto_err, rd_par_err, fill_state
  );

  modport slave (
    input  addr, serial_in, shift, load, w_en, r_en,
    output word_full, hold_valid, data_valid, data_out, proto_err, rd_par_err, fill_state
  );

endinterface

// File: rtl/sram_serial_loader.sv
// Serial word assembly: multi-lane shift register, fill FSM, holding register.
// Owns the shift-overflow and load-rejected flags.
module sram_serial_loader
  import sram_pkg::*;
#(
  parameter int COLS  = 8,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             shift,
  input  logic             load,
  input  logic             wr_commit,
  input  logic [LANES-1:0] serial_in,
  output logic             word_full,
  output logic             hold_valid,
  output logic [COLS-1:0]  hold_word,
  output logic [1:0]       proto_err,
  output fill_state_e      fill_state
);

  localparam int BEATS = COLS / LANES;
  localparam int CW    = $clog2(BEATS) + 1;

  fill_state_e     state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [COLS-1:0] sr_q, sr_d;
  logic [COLS-1:0] hold_q, hold_d;
  logic            hv_q, hv_d;
  logic [1:0]      err_q, err_d;
  logic            load_ok;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
      sr_q    <= '0;
      hold_q  <= '0;
      hv_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    hold_d  = hold_q;
    hv_d    = hv_q;
    err_d   = '0;
    load_ok = 1'b0;

    // Shift wins over load; a concurrent load is always refused.
    if (shift) begin
      if (load) err_d[ERR_LOAD_REJ] = 1'b1;
      if (state_q == FILL) begin
        sr_d  = COLS'({sr_q, serial_in});
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BEATS - 1)) state_d = FULL;
      end else begin
        err_d[ERR_SHIFT_OVF] = 1'b1;
      end
    end else if (load) begin
      // A commit on the same edge frees the holding register for the new word.
      if ((state_q == FULL) && (!hv_q || wr_commit)) load_ok = 1'b1;
      else                                           err_d[ERR_LOAD_REJ] = 1'b1;
    end

    if (load_ok) begin
      hold_d  = sr_q;
      hv_d    = 1'b1;
      cnt_d   = '0;
      sr_d    = '0;
      state_d = FILL;
    end else if (wr_commit) begin
      hv_d = 1'b0;
    end
  end

  assign word_full  = (state_q == FULL);
  assign hold_valid = hv_q;
  assign hold_word  = hold_q;
  assign proto_err  = err_q;
  assign fill_state = state_q;

endmodule

// File: rtl/sram_serial_ctrl.sv
// Serial-write SRAM top: row storage, holding-register commit and the RD_LAT-deep read pipeline.
// Define SRAM_PARITY_EN to store an even-parity bit per row and flag mismatches on read.
module sram_serial_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 8,
  parameter int LANES  = 1,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                arst_n,
  sram_serial_ctrl_if.slave   bus
);

  if ((COLS % LANES) != 0) begin : g_bad_lanes
    $error("COLS (%0d) must be a multiple of LANES (%0d)", COLS, LANES);
  end
  if ((RD_LAT < 1) || (RD_LAT > 4)) begin : g_bad_lat
    $error("RD_LAT (%0d) must be within 1..4", RD_LAT);
  end
  if (COLS > PAR_MAX_W) begin : g_bad_cols
    $error("COLS (%0d) exceeds %0d", COLS, PAR_MAX_W);
  end

  logic            hold_valid;
  logic [COLS-1:0] hold_word;
  logic [1:0]      ld_err;
  logic            wr_commit;
  logic            addr_ok;
  logic [COLS-1:0] rd_word;

  logic [COLS-1:0] mem_q [ROWS];
  logic [COLS-1:0] mem_d [ROWS];
  logic            rd_vld_q [RD_LAT];
  logic            rd_vld_d [RD_LAT];
  logic [COLS-1:0] rd_dat_q [RD_LAT];
  logic [COLS-1:0] rd_dat_d [RD_LAT];
  logic            wr_empty_q, wr_empty_d;

  assign wr_commit = bus.w_en & hold_valid;
  // Non-power-of-two depths leave unused address codes: writes there drop, reads return 0.
  assign addr_ok   = (32'(bus.addr) < ROWS);
  assign rd_word   = addr_ok ? mem_q[bus.addr] : '0;

  sram_serial_loader #(
    .COLS  (COLS),
    .LANES (LANES)
  ) u_loader (
    .clk        (clk),
    .arst_n     (arst_n),
    .shift      (bus.shift),
    .load       (bus.load),
    .wr_commit  (wr_commit),
    .serial_in  (bus.serial_in),
    .word_full  (bus.word_full),
    .hold_valid (hold_valid),
    .hold_word  (hold_word),
    .proto_err  (ld_err),
    .fill_state (bus.fill_state)
  );

  always_comb begin
    mem_d      = mem_q;
    rd_vld_d   = rd_vld_q;
    rd_dat_d   = rd_dat_q;
    wr_empty_d = bus.w_en & ~hold_valid;

    if (wr_commit && addr_ok) mem_d[bus.addr] = hold_word;

    // Stage data only advances with a valid read so data_out holds between reads.
    rd_vld_d[0] = bus.r_en;
    if (bus.r_en) rd_dat_d[0] = rd_word;
    for (int i = 1; i < RD_LAT; i++) begin
      rd_vld_d[i] = rd_vld_q[i-1];
      if (rd_vld_q[i-1]) rd_dat_d[i] = rd_dat_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < ROWS; i++) mem_q[i] <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        rd_vld_q[i] <= 1'b0;
        rd_dat_q[i] <= '0;
      end
      wr_empty_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      rd_vld_q   <= rd_vld_d;
      rd_dat_q   <= rd_dat_d;
      wr_empty_q <= wr_empty_d;
    end
  end

`ifdef SRAM_PARITY_EN
  logic [ROWS-1:0] mem_par_q, mem_par_d;
  logic            rd_perr_now;
  logic            rd_perr_q [RD_LAT];
  logic            rd_perr_d [RD_LAT];

  always_comb begin
    mem_par_d = mem_par_q;
    if (wr_commit && addr_ok) mem_par_d[bus.addr] = even_parity(PAR_MAX_W'(hold_word));
    rd_perr_now  = addr_ok && (even_parity(PAR_MAX_W'(rd_word)) != mem_par_q[bus.addr]);
    rd_perr_d[0] = bus.r_en & rd_perr_now;
    for (int i = 1; i < RD_LAT; i++) rd_perr_d[i] = rd_vld_q[i-1] & rd_perr_q[i-1];
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mem_par_q <= '0;
      for (int i = 0; i < RD_LAT; i++) rd_perr_q[i] <= 1'b0;
    end else begin
      mem_par_q <= mem_par_d;
      rd_perr_q <= rd_perr_d;
    end
  end

  assign bus.rd_par_err = rd_perr_q[RD_LAT-1];
`else
  assign bus.rd_par_err = 1'b0;
`endif

  assign bus.hold_valid = hold_valid;
  assign bus.data_valid = rd_vld_q[RD_LAT-1];
  assign bus.data_out   = rd_dat_q[RD_LAT-1];
  assign bus.proto_err  = {wr_empty_q, ld_err};

endmodule

// File: tb/tb_sram_serial_ctrl.sv
// Bench for sram_serial_ctrl: two instances (8x1-lane RD_LAT=1, 12 rows 2-lane RD_LAT=3)
// against a word-level reference model, plus directed literal expectations.
module tb_sram_serial_ctrl;
  import sram_pkg::*;

  localparam int NI = 2;

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  sram_serial_ctrl_if #(.ROWS(16), .COLS(8), .LANES(1)) ia ();
  sram_serial_ctrl_if #(.ROWS(12), .COLS(8), .LANES(2)) ib ();

  sram_serial_ctrl #(.ROWS(16), .COLS(8), .LANES(1), .RD_LAT(1)) u_a (
    .clk(clk), .arst_n(arst_n), .bus(ia)
  );
  sram_serial_ctrl #(.ROWS(12), .COLS(8), .LANES(2), .RD_LAT(3)) u_b (
    .clk(clk), .arst_n(arst_n), .bus(ib)
  );

  int lanes_of [NI] = '{1, 2};
  int rows_of  [NI] = '{16, 12};
  int lat_of   [NI] = '{1, 3};

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  typedef struct {
    int         inst;
    int         due;
    logic [7:0] data;
    bit         perr;
  } rd_t;

  rd_t        exp_q[$];
  int         m_beats [NI];
  logic [7:0] m_sr    [NI];
  logic [7:0] m_hold  [NI];
  bit         m_hv    [NI];
  logic [7:0] m_mem   [NI][16];
  logic [2:0] m_err   [NI];
  logic [7:0] m_dout  [NI];
  int         edge_n = 0;
  bit         par_row3_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_beats[k] = 0;
      m_sr[k]    = '0;
      m_hold[k]  = '0;
      m_hv[k]    = 1'b0;
      m_err[k]   = '0;
      m_dout[k]  = '0;
      for (int r = 0; r < 16; r++) m_mem[k][r] = '0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input int k, input bit sh, input logic [1:0] si, input bit ld,
                            input bit we, input bit re, input logic [3:0] ad);
    int         nb      = 8 / lanes_of[k];
    bit         full    = (m_beats[k] == nb);
    bit         wr_ok   = we && m_hv[k];
    bit         in_rng  = (int'(ad) < rows_of[k]);
    bit         load_ok = 1'b0;
    logic [2:0] err     = '0;
    rd_t        r;
    if (sh) begin
      if (ld) err[1] = 1'b1;
      if (full) err[0] = 1'b1;
      else begin
        m_sr[k] = 8'((m_sr[k] << lanes_of[k]) | si);
        m_beats[k]++;
      end
    end else if (ld) begin
      if (full && (!m_hv[k] || wr_ok)) load_ok = 1'b1;
      else err[1] = 1'b1;
    end
    if (we && !m_hv[k]) err[2] = 1'b1;
    if (re) begin
      r.inst = k;
      r.due  = edge_n + lat_of[k] - 1;
      r.data = in_rng ? m_mem[k][ad] : 8'h00;
      r.perr = par_row3_bad && (k == 0) && (ad == 4'd3);
      exp_q.push_back(r);
    end
    if (wr_ok && in_rng) m_mem[k][ad] = m_hold[k];
    if (load_ok) begin
      m_hold[k]  = m_sr[k];
      m_hv[k]    = 1'b1;
      m_sr[k]    = '0;
      m_beats[k] = 0;
    end else if (wr_ok) begin
      m_hv[k] = 1'b0;
    end
    m_err[k] = err;
  endtask

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) model_reset();
    else begin
      edge_n++;
      model_step(0, ia.shift, {1'b0, ia.serial_in}, ia.load, ia.w_en, ia.r_en, ia.addr);
      model_step(1, ib.shift, ib.serial_in, ib.load, ib.w_en, ib.r_en, ib.addr);
    end
  end

  // ---------------- compare process ----------------
  task automatic compare_inst(input int k);
    bit          e_dv = 1'b0;
    bit          e_pe = 1'b0;
    logic        wf, hv, dv, pe;
    logic [7:0]  dout;
    logic [2:0]  perr;
    fill_state_e fs;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].inst == k && exp_q[i].due == edge_n) begin
        e_dv      = 1'b1;
        e_pe      = exp_q[i].perr;
        m_dout[k] = exp_q[i].data;
        exp_q.delete(i);
        break;
      end
    end
    if (k == 0) begin
      wf = ia.word_full; hv = ia.hold_valid; dv = ia.data_valid; pe = ia.rd_par_err;
      dout = ia.data_out; perr = ia.proto_err; fs = ia.fill_state;
    end else begin
      wf = ib.word_full; hv = ib.hold_valid; dv = ib.data_valid; pe = ib.rd_par_err;
      dout = ib.data_out; perr = ib.proto_err; fs = ib.fill_state;
    end
    chk($sformatf("word_full[%0d]", k),  wf, m_beats[k] == 8 / lanes_of[k]);
    chk($sformatf("fill_state[%0d]", k), fs == FULL, m_beats[k] == 8 / lanes_of[k]);
    chk($sformatf("hold_valid[%0d]", k), hv, m_hv[k]);
    chk($sformatf("proto_err[%0d]", k),  perr, m_err[k]);
    chk($sformatf("data_valid[%0d]", k), dv, e_dv);
    chk($sformatf("data_out[%0d]", k),   dout, m_dout[k]);
    chk($sformatf("rd_par_err[%0d]", k), pe, e_pe);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) compare_inst(k);
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input int k, input bit sh, input logic [1:0] si, input bit ld,
                       input bit we, input bit re, input logic [3:0] ad);
    if (k == 0) begin
      ia.shift = sh; ia.serial_in = si[0]; ia.load = ld; ia.w_en = we; ia.r_en = re; ia.addr = ad;
    end else begin
      ib.shift = sh; ib.serial_in = si;    ib.load = ld; ib.w_en = we; ib.r_en = re; ib.addr = ad;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
    drive(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'd0);
  endtask

  // Shifts the first n beats of w, MSB side first.
  task automatic shift_word(input int k, input logic [7:0] w, input int n);
    logic [7:0] t = w;
    int         l = lanes_of[k];
    for (int i = 0; i < n; i++) begin
      idle();
      drive(k, 1'b1, (l == 1) ? {1'b0, t[7]} : t[7:6], 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      t = 8'(t << l);
    end
    idle();
  endtask

  task automatic do_load(input int k);
    idle(); drive(k, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 4'd0); tick(); idle();
  endtask

  task automatic do_write(input int k, input logic [3:0] ad);
    idle(); drive(k, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, ad); tick(); idle();
  endtask

  task automatic do_read(input int k, input logic [3:0] ad);
    idle(); drive(k, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, ad); tick(); idle();
  endtask

  logic [7:0] vals [3] = '{8'h3C, 8'hA5, 8'h0F};

  initial begin
    model_reset();
    idle();
    arst_n = 1'b0;
    tick(); tick();
    chk("rst word_full",  ia.word_full, 0);
    chk("rst hold_valid", ia.hold_valid, 0);
    chk("rst data_out",   ia.data_out, 0);
    chk("rst proto_err",  ib.proto_err, 0);
    arst_n = 1'b1;
    tick();

    // Default lane: 1,0,1,1,0,0,1,0 -> 0xB2, then a ninth shift overflows.
    shift_word(0, 8'hB2, 8);
    chk("full after 8 shifts", ia.word_full, 1);
    drive(0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 4'd0); tick(); idle();
    chk("ninth shift flag", ia.proto_err, 3'b001);
    tick();
    chk("overflow flag clears", ia.proto_err, 3'b000);
    do_load(0);
    chk("load hold_valid", ia.hold_valid, 1);
    chk("load empties shifter", ia.word_full, 0);
    do_write(0, 4'd3);
    chk("write clears hold", ia.hold_valid, 0);
    do_read(0, 4'd3);
    chk("read3 valid", ia.data_valid, 1);
    chk("read3 data", ia.data_out, 8'hB2);
    tick();
    chk("valid is a pulse", ia.data_valid, 0);
    chk("data_out holds", ia.data_out, 8'hB2);

    // Write with nothing held.
    do_write(0, 4'd4);
    chk("empty write flag", ia.proto_err, 3'b100);

    // Two lanes: 10,11,00,01 -> 0xB1 at row 5, RD_LAT=3.
    shift_word(1, 8'hB1, 4);
    chk("lanes2 full", ib.word_full, 1);
    do_load(1);
    do_write(1, 4'd5);
    drive(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 4'd5); tick(); idle();
    chk("lat3 not yet 1", ib.data_valid, 0);
    tick();
    chk("lat3 not yet 2", ib.data_valid, 0);
    tick();
    chk("lat3 valid", ib.data_valid, 1);
    chk("lat3 data", ib.data_out, 8'hB1);

    // Partial load is refused; the word then completes normally.
    shift_word(0, 8'h5A, 5);
    do_load(0);
    chk("partial load flag", ia.proto_err, 3'b010);
    chk("partial load no hold", ia.hold_valid, 0);
    shift_word(0, 8'b0100_0000, 3);
    chk("word completes", ia.word_full, 1);
    do_load(0);
    do_write(0, 4'd7);
    do_read(0, 4'd7);
    chk("row7 data", ia.data_out, 8'h5A);

    // Load+write same edge, then write+read same edge on row 2.
    shift_word(0, 8'h11, 8);
    do_load(0);
    shift_word(0, 8'h22, 8);
    drive(0, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 4'd2); tick(); idle();
    chk("load+write no flag", ia.proto_err, 3'b000);
    chk("load+write keeps hold", ia.hold_valid, 1);
    drive(0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1, 4'd2); tick(); idle();
    chk("read-before-write old", ia.data_out, 8'h11);
    chk("write consumed hold", ia.hold_valid, 0);
    do_read(0, 4'd2);
    chk("read new row2", ia.data_out, 8'h22);

    // Shift and load together: shift wins, load flagged.
    drive(0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0, 4'd0); tick(); idle();
    chk("shift+load flag", ia.proto_err, 3'b010);
    shift_word(0, 8'h80, 7);

    // Pipelined reads on rows 0..2 of the RD_LAT=3 instance.
    for (int i = 0; i < 3; i++) begin
      shift_word(1, vals[i], 4);
      do_load(1);
      do_write(1, 4'(i));
    end
    for (int i = 0; i < 3; i++) begin
      idle(); drive(1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 4'(i)); tick();
      chk("pipe valid timing", ib.data_valid, (i == 2) ? 1 : 0);
    end
    idle();
    chk("pipe data0", ib.data_out, 8'h3C);
    tick();
    chk("pipe data1", ib.data_out, 8'hA5);
    chk("pipe valid1", ib.data_valid, 1);
    tick();
    chk("pipe data2", ib.data_out, 8'h0F);
    tick();
    chk("pipe ends", ib.data_valid, 0);

    // Unused address code on the 12-row instance reads 0 with a valid pulse.
    do_read(1, 4'd14);
    tick(); tick();
    chk("oor read valid", ib.data_valid, 1);
    chk("oor read zero", ib.data_out, 8'h00);

    // Randomised traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < NI; k++)
        drive(k, $urandom_range(0, 9) < 4, 2'($urandom_range(0, 3)), $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4, 4'($urandom_range(0, 15)));
      tick();
    end
    idle();
    repeat (4) tick();

    // Asynchronous reset in the middle of a word with a word held.
    shift_word(0, 8'hC3, 8 - (ia.word_full ? 8 : 0));
    if (!ia.hold_valid) do_load(0);
    shift_word(0, 8'hF0, 4);
    #2 arst_n = 1'b0;
    #1;
    chk("async rst word_full", ia.word_full, 0);
    chk("async rst hold_valid", ia.hold_valid, 0);
    chk("async rst data_out", ia.data_out, 0);
    tick();
    arst_n = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) begin
      do_read(0, 4'(r));
      chk("row cleared", ia.data_out, 8'h00);
    end

`ifdef SRAM_PARITY_EN
    force u_a.mem_par_q[3] = 1'b1;
    par_row3_bad = 1'b1;
    do_read(0, 4'd3);
    chk("parity err valid", ia.data_valid, 1);
    chk("parity err flag", ia.rd_par_err, 1);
    do_read(0, 4'd4);
    chk("parity clean row", ia.rd_par_err, 0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
